// File: rtl/bti_mux.sv
// Many-to-one BTI interconnect: round-robin arbitration of host requests onto one guest port,
// with an in-order ID FIFO that routes guest responses back to the originating host.
module bti_mux #(
  parameter int unsigned BTI_AW     = 32,
  parameter int unsigned BTI_DW     = 32,
  parameter int unsigned HST_NUM    = 2,
  parameter int unsigned OSTD_DEPTH = 4,
  localparam int unsigned HID_W     = $clog2(HST_NUM)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  // host request channels (this block is slave)
  input  logic [HST_NUM-1:0]                  host_req_vld_i,
  output logic [HST_NUM-1:0]                  host_req_rdy_o,
  input  logic [HST_NUM-1:0][BTI_AW-1:0]      host_req_addr_i,
  input  logic [HST_NUM-1:0]                  host_req_wr_i,
  input  logic [HST_NUM-1:0][BTI_DW-1:0]      host_req_wdata_i,
  input  logic [HST_NUM-1:0][BTI_DW/8-1:0]    host_req_wstrb_i,
  // host response channels
  output logic [HST_NUM-1:0]                  host_rsp_vld_o,
  input  logic [HST_NUM-1:0]                  host_rsp_rdy_i,
  output logic [HST_NUM-1:0][BTI_DW-1:0]      host_rsp_rdata_o,
  // guest request channel
  output logic                                gst_req_vld_o,
  input  logic                                gst_req_rdy_i,
  output logic [BTI_AW-1:0]                   gst_req_addr_o,
  output logic                                gst_req_wr_o,
  output logic [BTI_DW-1:0]                   gst_req_wdata_o,
  output logic [BTI_DW/8-1:0]                 gst_req_wstrb_o,
  // guest response channel
  input  logic                                gst_rsp_vld_i,
  output logic                                gst_rsp_rdy_o,
  input  logic [BTI_DW-1:0]                   gst_rsp_rdata_i
);

  localparam int unsigned PW = $clog2(OSTD_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [HID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [HID_W-1:0] locked_id_q, locked_id_d;
  logic             lock_q, lock_d;
  logic [HID_W-1:0] fifo_mem_q [OSTD_DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [HID_W-1:0] idx, cand, grant, head;
  logic             cand_vld, grant_vld;
  logic             fifo_full, fifo_empty, req_hs, rsp_hs;

  assign fifo_full  = (cnt_q == CW'(OSTD_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_mem_q[rptr_q];

  // First requesting host at or above rr_ptr, wrapping modulo HST_NUM.
  always_comb begin
    idx      = '0;
    cand     = rr_ptr_q;
    cand_vld = 1'b0;
    for (int unsigned i = 0; i < HST_NUM; i++) begin
      idx = HID_W'((32'(rr_ptr_q) + i) % HST_NUM);
      if (!cand_vld && host_req_vld_i[idx]) begin
        cand_vld = 1'b1;
        cand     = idx;
      end
    end
  end

  // A stalled guest request keeps its grant so the presented fields stay stable.
  always_comb begin
    grant     = lock_q ? locked_id_q : cand;
    grant_vld = lock_q ? host_req_vld_i[locked_id_q] : cand_vld;
  end

  always_comb begin
    gst_req_vld_o   = rst_n && grant_vld && !fifo_full;
    gst_req_addr_o  = host_req_addr_i[grant];
    gst_req_wr_o    = host_req_wr_i[grant];
    gst_req_wdata_o = host_req_wdata_i[grant];
    gst_req_wstrb_o = host_req_wstrb_i[grant];
    host_req_rdy_o  = '0;
    if (rst_n && grant_vld && !fifo_full && gst_req_rdy_i) begin
      host_req_rdy_o[grant] = 1'b1;
    end
    req_hs = gst_req_vld_o && gst_req_rdy_i;
  end

  // Responses with nothing outstanding are accepted and dropped.
  always_comb begin
    host_rsp_vld_o = '0;
    if (rst_n && gst_rsp_vld_i && !fifo_empty) begin
      host_rsp_vld_o[head] = 1'b1;
    end
    for (int unsigned i = 0; i < HST_NUM; i++) begin
      host_rsp_rdata_o[i] = gst_rsp_rdata_i;
    end
    gst_rsp_rdy_o = rst_n && (fifo_empty || host_rsp_rdy_i[head]);
    rsp_hs        = gst_rsp_vld_i && gst_rsp_rdy_o && !fifo_empty;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    if (req_hs) begin
      rr_ptr_d = (grant == HID_W'(HST_NUM - 1)) ? '0 : grant + HID_W'(1);
      lock_d   = 1'b0;
      wptr_d   = wptr_q + PW'(1);
    end else if (gst_req_vld_o) begin
      lock_d      = 1'b1;
      locked_id_d = grant;
    end
    if (rsp_hs) begin
      rptr_d = rptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(req_hs) - CW'(rsp_hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < OSTD_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      if (req_hs) begin
        fifo_mem_q[wptr_q] <= grant;
      end
    end
  end

`ifndef SYNTHESIS
  rsp_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(gst_rsp_vld_i && fifo_empty))
    else $warning("bti_mux: guest response with no outstanding request dropped");

  locked_host_holds_vld: assert property (@(posedge clk) disable iff (!rst_n)
    !(lock_q && !host_req_vld_i[locked_id_q]))
    else $error("bti_mux: locked host withdrew its request");
`endif

endmodule

// File: tb/tb_bti_mux.sv
// Self-checking bench for bti_mux: directed scenarios plus randomized traffic scored against a
// queue-based model of the arbitration and in-order response routing rules.
module tb_bti_mux;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 2;
  localparam int unsigned D  = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [N-1:0]               h_vld, h_rdy, h_wr, hr_vld, hr_rdy;
  logic [N-1:0][AW-1:0]       h_addr;
  logic [N-1:0][DW-1:0]       h_wdata, hr_rdata;
  logic [N-1:0][DW/8-1:0]     h_wstrb;
  logic                       g_vld, g_rdy, g_wr, gr_vld, gr_rdy;
  logic [AW-1:0]              g_addr;
  logic [DW-1:0]              g_wdata, gr_rdata;
  logic [DW/8-1:0]            g_wstrb;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h1000_0004;
  localparam logic [DW-1:0] W0 = 32'hAAAA_0000;
  localparam logic [DW-1:0] W1 = 32'h5555_0001;

  always #5 clk = ~clk;

  bti_mux #(.BTI_AW(AW), .BTI_DW(DW), .HST_NUM(N), .OSTD_DEPTH(D)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .host_req_vld_i   (h_vld),
    .host_req_rdy_o   (h_rdy),
    .host_req_addr_i  (h_addr),
    .host_req_wr_i    (h_wr),
    .host_req_wdata_i (h_wdata),
    .host_req_wstrb_i (h_wstrb),
    .host_rsp_vld_o   (hr_vld),
    .host_rsp_rdy_i   (hr_rdy),
    .host_rsp_rdata_o (hr_rdata),
    .gst_req_vld_o    (g_vld),
    .gst_req_rdy_i    (g_rdy),
    .gst_req_addr_o   (g_addr),
    .gst_req_wr_o     (g_wr),
    .gst_req_wdata_o  (g_wdata),
    .gst_req_wstrb_o  (g_wstrb),
    .gst_rsp_vld_i    (gr_vld),
    .gst_rsp_rdy_o    (gr_rdy),
    .gst_rsp_rdata_i  (gr_rdata)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    h_vld    = '0;
    h_wr     = '0;
    h_addr   = {A1, A0};
    h_wdata  = {W1, W0};
    h_wstrb  = '1;
    hr_rdy   = '0;
    g_rdy    = 1'b0;
    gr_vld   = 1'b0;
    gr_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    h_vld  = 2'b11;
    g_rdy  = 1'b1;
    gr_vld = 1'b1;
    hr_rdy = 2'b11;
    @(negedge clk);
    n_chk++;
    if ({g_vld, h_rdy, hr_vld, gr_rdy} !== 6'b0)
      $display("FAIL reset_outputs: got g_vld=%b h_rdy=%b hr_vld=%b gr_rdy=%b want all 0",
               g_vld, h_rdy, hr_vld, gr_rdy);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_chk++;
    if (gr_rdy !== 1'b1) $display("FAIL reset_empty_rsp_rdy: got %b want 1", gr_rdy);
    else n_pass++;
    nxt();
  endtask

  task automatic test_single();
    do_reset();
    h_vld     = 2'b01;
    h_addr[0] = 32'h2000_0010;
    g_rdy     = 1'b1;
    hr_rdy    = 2'b11;
    @(negedge clk);
    n_chk++;
    if (g_vld !== 1'b1 || g_addr !== 32'h2000_0010 || g_wr !== 1'b0)
      $display("FAIL single_req: got vld=%b addr=%h wr=%b want 1 20000010 0", g_vld, g_addr, g_wr);
    else n_pass++;
    n_chk++;
    if (h_rdy !== 2'b01) $display("FAIL single_rdy: got %b want 01", h_rdy);
    else n_pass++;
    nxt();
    h_vld    = 2'b00;
    gr_vld   = 1'b1;
    gr_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++;
    if (hr_vld !== 2'b01 || hr_rdata[0] !== 32'hDEAD_BEEF || gr_rdy !== 1'b1)
      $display("FAIL single_rsp: got hr_vld=%b rdata=%h gr_rdy=%b want 01 deadbeef 1",
               hr_vld, hr_rdata[0], gr_rdy);
    else n_pass++;
    nxt();
    gr_vld = 1'b0;
  endtask

  task automatic test_contention();
    int c0 = 0;
    int c1 = 0;
    do_reset();
    h_vld  = 2'b11;
    g_rdy  = 1'b1;
    hr_rdy = 2'b11;
    for (int k = 0; k < 16; k++) begin
      gr_vld   = (k > 0);
      gr_rdata = DW'(k);
      @(negedge clk);
      n_chk++;
      if (g_addr !== ((k % 2) ? A1 : A0) || h_rdy !== (2'b01 << (k % 2)))
        $display("FAIL contention_grant[%0d]: got addr=%h rdy=%b want host %0d", k, g_addr, h_rdy,
                 k % 2);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (hr_vld !== (2'b01 << ((k - 1) % 2)))
          $display("FAIL contention_route[%0d]: got %b want host %0d", k, hr_vld, (k - 1) % 2);
        else n_pass++;
      end
      if (h_rdy[0] === 1'b1) c0++;
      if (h_rdy[1] === 1'b1) c1++;
      nxt();
    end
    n_chk++;
    if (c0 != 8 || c1 != 8) $display("FAIL contention_share: got %0d/%0d want 8/8", c0, c1);
    else n_pass++;
    h_vld  = '0;
    gr_vld = 1'b0;
  endtask

  task automatic test_stall_lock();
    do_reset();
    hr_rdy = 2'b11;
    h_vld  = 2'b01;
    g_rdy  = 1'b1;
    @(negedge clk);
    n_chk++;
    if (h_rdy !== 2'b01) $display("FAIL lock_first: got %b want 01", h_rdy);
    else n_pass++;
    nxt();
    // rr now favours host1, but host0 is the only requester when the stall begins
    g_rdy  = 1'b0;
    gr_vld = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_chk++;
      if (g_vld !== 1'b1 || g_addr !== A0 || g_wdata !== W0 || h_rdy !== 2'b00)
        $display("FAIL lock_stall[%0d]: got vld=%b addr=%h wdata=%h rdy=%b want 1 %h %h 00",
                 s, g_vld, g_addr, g_wdata, h_rdy, A0, W0);
      else n_pass++;
      if (s == 0) begin
        n_chk++;
        if (hr_vld !== 2'b01) $display("FAIL lock_rsp: got %b want 01", hr_vld);
        else n_pass++;
      end
      nxt();
      gr_vld = 1'b0;
      h_vld  = 2'b11;
    end
    g_rdy = 1'b1;
    @(negedge clk);
    n_chk++;
    if (g_addr !== A0 || h_rdy !== 2'b01)
      $display("FAIL lock_release: got addr=%h rdy=%b want %h 01", g_addr, h_rdy, A0);
    else n_pass++;
    nxt();
    h_vld = 2'b10;
    @(negedge clk);
    n_chk++;
    if (g_addr !== A1 || h_rdy !== 2'b10)
      $display("FAIL lock_next: got addr=%h rdy=%b want %h 10", g_addr, h_rdy, A1);
    else n_pass++;
    nxt();
    h_vld = '0;
  endtask

  task automatic test_ostd_limit();
    do_reset();
    h_vld  = 2'b11;
    g_rdy  = 1'b1;
    hr_rdy = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if (k < 4 && h_rdy !== (2'b01 << (k % 2)))
        $display("FAIL ostd_accept[%0d]: got %b want host %0d", k, h_rdy, k % 2);
      else if (k >= 4 && (h_rdy !== 2'b00 || g_vld !== 1'b0))
        $display("FAIL ostd_full[%0d]: got rdy=%b vld=%b want 00 0", k, h_rdy, g_vld);
      else n_pass++;
      nxt();
    end
    gr_vld = 1'b1;
    for (int k = 6; k < 11; k++) begin
      h_vld    = (k <= 7) ? 2'b11 : 2'b00;
      gr_rdata = DW'(k);
      @(negedge clk);
      n_chk++;
      if (hr_vld !== (2'b01 << ((k - 6) % 2)))
        $display("FAIL ostd_route[%0d]: got %b want host %0d", k, hr_vld, (k - 6) % 2);
      else n_pass++;
      if (k == 6) begin
        n_chk++;
        if (h_rdy !== 2'b00) $display("FAIL ostd_no_bypass: got %b want 00", h_rdy);
        else n_pass++;
      end
      if (k == 7) begin
        n_chk++;
        if (h_rdy !== 2'b01) $display("FAIL ostd_resume: got %b want 01", h_rdy);
        else n_pass++;
      end
      nxt();
    end
    gr_vld = 1'b0;
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    h_vld  = 2'b10;
    g_rdy  = 1'b1;
    hr_rdy = 2'b11;
    @(negedge clk);
    n_chk++;
    if (g_vld !== 1'b1 || g_addr !== A1 || h_rdy !== 2'b10)
      $display("FAIL bp_req: got vld=%b addr=%h rdy=%b want 1 %h 10", g_vld, g_addr, h_rdy, A1);
    else n_pass++;
    nxt();
    h_vld    = 2'b00;
    gr_vld   = 1'b1;
    gr_rdata = 32'hCAFE_F00D;
    hr_rdy   = 2'b01;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      n_chk++;
      if (hr_vld !== 2'b10 || gr_rdy !== 1'b0)
        $display("FAIL bp_hold[%0d]: got hr_vld=%b gr_rdy=%b want 10 0", s, hr_vld, gr_rdy);
      else n_pass++;
      nxt();
    end
    hr_rdy = 2'b11;
    @(negedge clk);
    n_chk++;
    if (hr_vld !== 2'b10 || gr_rdy !== 1'b1 || hr_rdata[1] !== 32'hCAFE_F00D)
      $display("FAIL bp_deliver: got hr_vld=%b gr_rdy=%b rdata=%h want 10 1 cafef00d",
               hr_vld, gr_rdy, hr_rdata[1]);
    else n_pass++;
    nxt();
    gr_vld = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    h_vld  = 2'b11;
    g_rdy  = 1'b1;
    hr_rdy = 2'b11;
    nxt();
    nxt();
    gr_vld = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({g_vld, h_rdy, hr_vld, gr_rdy} !== 6'b0)
      $display("FAIL midreset_outputs: got g_vld=%b h_rdy=%b hr_vld=%b gr_rdy=%b want all 0",
               g_vld, h_rdy, hr_vld, gr_rdy);
    else n_pass++;
    h_vld  = 2'b00;
    gr_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
    gr_vld = 1'b1;
    @(negedge clk);
    n_chk++;
    if (gr_rdy !== 1'b1 || hr_vld !== 2'b00)
      $display("FAIL midreset_stray: got gr_rdy=%b hr_vld=%b want 1 00", gr_rdy, hr_vld);
    else n_pass++;
    nxt();
    gr_vld = 1'b0;
    h_vld  = 2'b10;
    @(negedge clk);
    n_chk++;
    if (g_vld !== 1'b1 || h_rdy !== 2'b10)
      $display("FAIL midreset_req: got vld=%b rdy=%b want 1 10", g_vld, h_rdy);
    else n_pass++;
    nxt();
    h_vld  = 2'b00;
    gr_vld = 1'b1;
    @(negedge clk);
    n_chk++;
    if (hr_vld !== 2'b10) $display("FAIL midreset_route: got %b want 10", hr_vld);
    else n_pass++;
    nxt();
    gr_vld = 1'b0;
  endtask

  task automatic test_random();
    int           q[$];
    int           rr, lid, cand, gnt;
    bit           lk, found, gv, e_gvld, e_grrdy;
    logic [N-1:0] last_hs, e_hrdy, e_hrvld;
    do_reset();
    rr      = 0;
    lk      = 1'b0;
    lid     = 0;
    last_hs = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(h_vld[i] && !last_hs[i])) begin
          h_vld[i]   = ($urandom_range(0, 3) != 0);
          h_addr[i]  = $urandom;
          h_wdata[i] = $urandom;
          h_wr[i]    = 1'($urandom_range(0, 1));
          h_wstrb[i] = 4'($urandom);
        end
      end
      g_rdy    = ($urandom_range(0, 2) != 0);
      hr_rdy   = N'($urandom);
      gr_vld   = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      gr_rdata = $urandom;
      @(negedge clk);
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && h_vld[(rr + i) % N]) begin
          found = 1'b1;
          cand  = (rr + i) % N;
        end
      end
      gnt     = lk ? lid : cand;
      gv      = lk ? h_vld[lid] : found;
      e_gvld  = gv && (q.size() < D);
      e_hrdy  = (e_gvld && g_rdy) ? (N'(1) << gnt) : '0;
      e_hrvld = (gr_vld && q.size() > 0) ? (N'(1) << q[0]) : '0;
      e_grrdy = (q.size() == 0) ? 1'b1 : hr_rdy[q[0]];
      n_chk++;
      if (g_vld !== e_gvld || h_rdy !== e_hrdy)
        $display("FAIL rand_req[%0d]: got vld=%b rdy=%b want %b %b", c, g_vld, h_rdy, e_gvld, e_hrdy);
      else n_pass++;
      n_chk++;
      if (hr_vld !== e_hrvld || gr_rdy !== e_grrdy)
        $display("FAIL rand_rsp[%0d]: got hr_vld=%b gr_rdy=%b want %b %b", c, hr_vld, gr_rdy,
                 e_hrvld, e_grrdy);
      else n_pass++;
      n_chk++;
      if (hr_rdata !== {N{gr_rdata}})
        $display("FAIL rand_rdata[%0d]: got %h want %h broadcast", c, hr_rdata, gr_rdata);
      else n_pass++;
      if (e_gvld) begin
        n_chk++;
        if ({g_addr, g_wr, g_wdata, g_wstrb} !== {h_addr[gnt], h_wr[gnt], h_wdata[gnt], h_wstrb[gnt]})
          $display("FAIL rand_fields[%0d]: got addr=%h wdata=%h want host %0d addr=%h wdata=%h",
                   c, g_addr, g_wdata, gnt, h_addr[gnt], h_wdata[gnt]);
        else n_pass++;
      end
      if (gr_vld && e_grrdy && q.size() > 0) void'(q.pop_front());
      if (e_gvld && g_rdy) begin
        q.push_back(gnt);
        rr = (gnt + 1) % N;
        lk = 1'b0;
      end else if (e_gvld) begin
        lk  = 1'b1;
        lid = gnt;
      end
      last_hs = e_hrdy;
      nxt();
    end
    h_vld  = '0;
    gr_vld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_stall_lock();
    test_ostd_limit();
    test_rsp_backpressure();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
